// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding FFT stage 0: collects DEPTH vectors per bank and
// replays each complete frame as an unbroken burst while the other bank fills.
module fft_frame_buffer #(
  parameter int DATA  = 9,
  parameter int ARRAY = 16,
  parameter int DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [DATA*ARRAY-1:0]  s_re,
  input  logic signed [DATA*ARRAY-1:0]  s_im,
  output logic                          valid_out,
  output logic                          frame_start,
  output logic signed [DATA*ARRAY-1:0]  dout_re,
  output logic signed [DATA*ARRAY-1:0]  dout_im
);

  localparam int LW = DATA * ARRAY;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_next;
  logic              wr_bank, rd_bank;
  logic [CW-1:0]     wr_cnt, rd_cnt;
  logic [1:0]        bank_full, bank_full_next;
  logic              accept, wr_last, rd_en, rd_last;
  logic [2*LW-1:0]   mem [0:2*DEPTH-1];
  logic [2*LW-1:0]   entry_p0;

  logic              vld_p1, fs_p1;
  logic signed [LW-1:0] re_p1, im_p1;

  assign s_ready = !bank_full[wr_bank];
  assign accept  = s_valid && s_ready;
  assign wr_last = accept && (wr_cnt == LAST);

  // write side: bank/address counters and storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (accept) begin
      if (wr_cnt == LAST) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank, wr_cnt}] <= {s_re, s_im};
  end

  // read FSM: a burst chains straight into the next if the other bank is already full
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_last    = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) state_next = BURST;
      end
      BURST: begin
        rd_en = 1'b1;
        if (rd_cnt == LAST) begin
          rd_last = 1'b1;
          if (!bank_full[~rd_bank]) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // writer and reader never touch the same bank flag in one cycle
  always_comb begin
    bank_full_next = bank_full;
    if (rd_last) bank_full_next[rd_bank] = 1'b0;
    if (wr_last) bank_full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      bank_full <= '0;
    end else begin
      state     <= state_next;
      bank_full <= bank_full_next;
      if (rd_en) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // stage p0 -> p1: registered output, data held while idle
  assign entry_p0 = mem[{rd_bank, rd_cnt}];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      fs_p1  <= 1'b0;
      re_p1  <= '0;
      im_p1  <= '0;
    end else begin
      vld_p1 <= rd_en;
      fs_p1  <= rd_en && (rd_cnt == '0);
      if (rd_en) begin
        re_p1 <= entry_p0[2*LW-1:LW];
        im_p1 <= entry_p0[LW-1:0];
      end
    end
  end

  assign valid_out   = vld_p1;
  assign frame_start = fs_p1;
  assign dout_re     = re_p1;
  assign dout_im     = im_p1;

endmodule
